// File: rtl/msg_assembler_if.sv
// AXI-Stream beat bus feeding msg_assembler; the master drives the beat, the slave drives s_tready.
interface msg_assembler_if #(
  parameter int DATA_BYTES = 8
);
  logic                    s_tready;
  logic                    s_tvalid;
  logic                    s_tlast;
  logic [8*DATA_BYTES-1:0] s_tdata;
  logic [DATA_BYTES-1:0]   s_tkeep;
  logic                    s_tuser;

  modport master (
    output s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser,
    input  s_tready
  );

  modport slave (
    input  s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser,
    output s_tready
  );
endinterface

// File: rtl/msg_assembler.sv
// Packs a multi-beat AXI-ST message into one wide word; optional idle timeout via MSG_ASM_TIMEOUT_EN.
// Latency: msg_valid pulses the cycle after the tlast handshake (or after the idle limit when timeout is built in).
// Backpressure: s_tready=1 while accumulating, 0 for the single EMIT bubble; outputs are never stalled.
module msg_assembler #(
  parameter int DATA_BYTES     = 8,
  parameter int MAX_MSG_BYTES  = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  msg_assembler_if.slave             s,
  output logic                       msg_valid,
  output logic [15:0]                msg_length,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic                       msg_error
);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                     state, state_nx;
  logic [8*MAX_MSG_BYTES-1:0] acc, acc_nx;
  logic [15:0]                count, count_nx;
  logic                       sticky, sticky_nx;
  logic                       hs, load, load_err, keep_ok;
  logic [DATA_BYTES-1:0]      keep_p1;
  logic [16:0]                sum;
  int                         n_bytes;

`ifdef MSG_ASM_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        beat_seen;
  logic        timeout;

  assign timeout = ((count != 16'd0) || beat_seen) && (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_nx   = state;
    s.s_tready = 1'b0;
    acc_nx     = acc;
    count_nx   = count;
    sticky_nx  = sticky;
    load       = 1'b0;
    load_err   = 1'b0;
    hs         = 1'b0;
    keep_ok    = 1'b0;
    sum        = '0;
    n_bytes    = 0;
    keep_p1    = s.s_tkeep + {{(DATA_BYTES-1){1'b0}}, 1'b1};
    for (int i = 0; i < DATA_BYTES; i++) n_bytes = n_bytes + int'(s.s_tkeep[i]);

    case (state)
      ACCUM: begin
        s.s_tready = rst;
        hs         = s.s_tvalid && rst;
        // Last beat may be any run of ones from bit 0; earlier beats are all-ones or null.
        keep_ok    = s.s_tlast ? ((s.s_tkeep & keep_p1) == '0)
                               : ((&s.s_tkeep) || (~|s.s_tkeep));
        if (hs) begin
          if (keep_ok) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (i < n_bytes) begin
                if (int'(count) + i >= MAX_MSG_BYTES) sticky_nx = 1'b1;
                for (int j = 0; j < MAX_MSG_BYTES; j++)
                  if (j == int'(count) + i) acc_nx[j*8 +: 8] = s.s_tdata[i*8 +: 8];
              end
            end
            sum      = {1'b0, count} + 17'(n_bytes);
            count_nx = sum[16] ? 16'hFFFF : sum[15:0];
          end else begin
            // Malformed beat contributes neither bytes nor length.
            sticky_nx = 1'b1;
          end
          if (s.s_tlast) begin
            load     = 1'b1;
            load_err = sticky_nx | s.s_tuser;
            state_nx = EMIT;
          end
        end
`ifdef MSG_ASM_TIMEOUT_EN
        else if (timeout) begin
          load     = 1'b1;
          load_err = 1'b1;
          state_nx = EMIT;
        end
`endif
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ACCUM;
      acc        <= '0;
      count      <= '0;
      sticky     <= 1'b0;
      msg_valid  <= 1'b0;
      msg_length <= '0;
      msg_data   <= '0;
      msg_error  <= 1'b0;
`ifdef MSG_ASM_TIMEOUT_EN
      idle_cnt   <= '0;
      beat_seen  <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      msg_valid <= load;
      if (load) begin
        msg_length <= count_nx;
        msg_data   <= acc_nx;
        msg_error  <= load_err;
        acc        <= '0;
        count      <= '0;
        sticky     <= 1'b0;
      end else begin
        acc    <= acc_nx;
        count  <= count_nx;
        sticky <= sticky_nx;
      end
`ifdef MSG_ASM_TIMEOUT_EN
      if (load) begin
        idle_cnt  <= '0;
        beat_seen <= 1'b0;
      end else if (hs) begin
        idle_cnt  <= '0;
        beat_seen <= 1'b1;
      end else if ((state == ACCUM) && ((count != 16'd0) || beat_seen)) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
`endif
    end
  end

endmodule
